l1_data_ram_1w1r: RTL

L1_DATA_RAM_1W1R -- requirements
Module: l1_data_ram_1w1r

---
 rtl/l1_ram_pkg.sv | 38 +++
 rtl/l1_ram_init_seq.sv | 53 +++++
 rtl/l1_data_ram_1w1r.sv | 103 ++++++++++
 3 files changed

// File: rtl/l1_ram_pkg.sv
// Shared types and helpers for the L1 data RAM: FSM states, default sizing
// and the byte-merge used by both the array write port and the bypass path.
package l1_ram_pkg;

    localparam int DEF_DATA_WIDTH   = 256;
    localparam int DEF_ADDR_WIDTH   = 8;
    localparam int DEF_BYTE_WIDTH   = 8;
    localparam int DEF_READ_LATENCY = 1;

    // Upper bound on word width the merge helper handles; callers size-cast in and out.
    localparam int MAX_DATA_WIDTH   = 1024;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } ram_state_e;

    function automatic logic [MAX_DATA_WIDTH-1:0] byte_merge(
        input logic [MAX_DATA_WIDTH-1:0] old_word,
        input logic [MAX_DATA_WIDTH-1:0] new_word,
        input logic [MAX_DATA_WIDTH-1:0] mask,
        input int                        byte_w
    );
        logic [MAX_DATA_WIDTH-1:0] bit_mask;
        logic [MAX_DATA_WIDTH-1:0] lane_ones;
        logic [MAX_DATA_WIDTH-1:0] m;
        bit_mask  = '0;
        lane_ones = ~({MAX_DATA_WIDTH{1'b1}} << byte_w);
        m         = mask;
        // Expand one mask bit per lane into byte_w data bits, LSB lane first.
        for (int b = 0; b < MAX_DATA_WIDTH; b++) begin
            if (m[0]) bit_mask = bit_mask | (lane_ones << (b * byte_w));
            m = m >> 1;
        end
        return (old_word & ~bit_mask) | (new_word & bit_mask);
    endfunction

endpackage

// File: rtl/l1_ram_init_seq.sv
// Clear-sweep sequencer: after reset walks every address once emitting a
// zero-write strobe, then parks in READY until the next reset.
module l1_ram_init_seq
    import l1_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    output logic                  o_init_busy,
    output logic [ADDR_WIDTH-1:0] o_clr_addr,
    output logic                  o_clr_we
);

    ram_state_e            r_state;
    ram_state_e            w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [ADDR_WIDTH-1:0] w_cnt_nxt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        o_init_busy = 1'b0;
        o_clr_we    = 1'b0;
        case (r_state)
            INIT: begin
                o_init_busy = 1'b1;
                o_clr_we    = ~i_rst;
                w_cnt_nxt   = r_cnt + 1'b1;
                if (r_cnt == {ADDR_WIDTH{1'b1}}) w_state_nxt = READY;
            end
            READY: begin
                w_state_nxt = READY;
            end
            default: begin
                w_state_nxt = INIT;
            end
        endcase
    end

    assign o_clr_addr = r_cnt;

endmodule

// File: rtl/l1_data_ram_1w1r.sv
// One-write/one-read L1 data RAM with byte masks, self-clearing after reset and
// a 1- or 2-cycle read pipeline. Define L1_RAM_BYPASS_EN for write-first collisions.
module l1_data_ram_1w1r
    import l1_ram_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int BYTE_WIDTH   = DEF_BYTE_WIDTH,
    parameter int READ_LATENCY = DEF_READ_LATENCY,
    localparam int NUM_WMASKS  = DATA_WIDTH / BYTE_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [NUM_WMASKS-1:0] wr_mask,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  init_busy
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("l1_data_ram_1w1r: READ_LATENCY must be 1 or 2");
    end
    if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_byte_width
        $error("l1_data_ram_1w1r: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end
    if (DATA_WIDTH > MAX_DATA_WIDTH) begin : g_bad_data_width
        $error("l1_data_ram_1w1r: DATA_WIDTH exceeds byte_merge capacity");
    end

    logic                  w_init_busy;
    logic [ADDR_WIDTH-1:0] w_clr_addr;
    logic                  w_clr_we;

    l1_ram_init_seq #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_init_seq (
        .i_clk       (clk),
        .i_rst       (rst),
        .o_init_busy (w_init_busy),
        .o_clr_addr  (w_clr_addr),
        .o_clr_we    (w_clr_we)
    );

    assign init_busy = w_init_busy;

    // Requests are dropped while sweeping or in the reset cycle itself.
    logic w_wr_acc;
    logic w_rd_acc;
    assign w_wr_acc = wr_en & ~w_init_busy & ~rst;
    assign w_rd_acc = rd_en & ~w_init_busy & ~rst;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] w_wr_merged;
    logic [DATA_WIDTH-1:0] w_rd_word;

    assign w_wr_merged = DATA_WIDTH'(byte_merge(MAX_DATA_WIDTH'(r_mem[wr_addr]),
                                                MAX_DATA_WIDTH'(wr_data),
                                                MAX_DATA_WIDTH'(wr_mask),
                                                BYTE_WIDTH));

    always_ff @(posedge clk) begin
        if (w_clr_we)
            r_mem[w_clr_addr] <= '0;
        else if (w_wr_acc)
            r_mem[wr_addr] <= w_wr_merged;
    end

`ifdef L1_RAM_BYPASS_EN
    // Same address means r_mem[wr_addr] is the old word, so the merge is the post-write value.
    assign w_rd_word = (w_wr_acc && (wr_addr == rd_addr)) ? w_wr_merged : r_mem[rd_addr];
`else
    assign w_rd_word = r_mem[rd_addr];
`endif

    // Each stage's data only advances with its valid so the output holds between reads.
    logic [READ_LATENCY-1:0] r_vld_pipe;
    logic [DATA_WIDTH-1:0]   r_dat_pipe [READ_LATENCY];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_pipe <= '0;
            for (int s = 0; s < READ_LATENCY; s++) r_dat_pipe[s] <= '0;
        end else begin
            r_vld_pipe[0] <= w_rd_acc;
            if (w_rd_acc) r_dat_pipe[0] <= w_rd_word;
            for (int s = 1; s < READ_LATENCY; s++) begin
                r_vld_pipe[s] <= r_vld_pipe[s-1];
                if (r_vld_pipe[s-1]) r_dat_pipe[s] <= r_dat_pipe[s-1];
            end
        end
    end

    assign rd_valid = r_vld_pipe[READ_LATENCY-1];
    assign rd_data  = r_dat_pipe[READ_LATENCY-1];

endmodule
